// File: rtl/question_bank.sv
// question_bank: writable question store for the factorisation game.
// Holds NUM_Q packed {LEVEL, ANSER, NUM_ARRAY} entries and serves one entry per
// request in sequential, pseudo-random or direct-index order. An optional level
// filter applies, and a used mask keeps scans from repeating an entry.
module question_bank #(
  parameter int NUM_Q = 16,
  parameter int ARR_W = 36,
  parameter int ANS_W = 8,
  parameter int LEV_W = 2,
  parameter int IDX_W = $clog2(NUM_Q)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         WE,
  input  logic [IDX_W-1:0]             WADDR,
  input  logic [LEV_W+ANS_W+ARR_W-1:0] WDATA,
  input  logic                         REQ,
  input  logic [1:0]                   MODE,
  input  logic [LEV_W-1:0]             LEVEL_SEL,
  input  logic [IDX_W-1:0]             REQ_ID,
  input  logic                         CLR_USED,
  output logic [ARR_W-1:0]             NUM_ARRAY,
  output logic [ANS_W-1:0]             ANSER,
  output logic [LEV_W-1:0]             LEVEL,
  output logic [IDX_W-1:0]             Q_ID,
  output logic                         VALID,
  output logic                         EMPTY,
  output logic                         BUSY,
  output logic [IDX_W:0]               REMAIN
);

  localparam int ENT_W = LEV_W + ANS_W + ARR_W;
  localparam logic [IDX_W:0]   QN      = (IDX_W+1)'(NUM_Q);
  localparam logic [IDX_W-1:0] LAST_ID = IDX_W'(NUM_Q - 1);
  localparam logic [15:0]      QN16    = 16'(NUM_Q);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t              state_q, state_d;
  logic [ENT_W-1:0]    mem_q [NUM_Q];
  logic [ENT_W-1:0]    mem_d [NUM_Q];
  logic [NUM_Q-1:0]    used_q, used_d;
  logic [IDX_W-1:0]    last_q, last_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic                dir_q, dir_d;
  logic [LEV_W-1:0]    lsel_q, lsel_d;
  logic [ARR_W-1:0]    arr_q, arr_d;
  logic [ANS_W-1:0]    ans_q, ans_d;
  logic [LEV_W-1:0]    lev_q, lev_d;
  logic [IDX_W-1:0]    qid_q, qid_d;
  logic                valid_q, valid_d;
  logic                empty_q, empty_d;
  logic [IDX_W:0]      remain_q, remain_d;

  logic                busy;
  logic                in_range;
  logic [IDX_W-1:0]    rd_idx;
  logic [ENT_W-1:0]    rd_entry;
  logic                lev_match;
  logic                hit;
  logic                exhausted;

  // Advance an index by one, wrapping NUM_Q-1 back to 0.
  function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] p);
    if ({1'b0, p} >= QN - 1'b1) return '0;
    return p + 1'b1;
  endfunction

  // Galois LFSR step for x^16+x^14+x^13+x^11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  assign busy = (state_q == S_SCAN);

  // State register; CLR_USED and RST both force the machine back to IDLE.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Evaluate the entry under the scan pointer (direct indices may be out of range).
  always_comb begin
    in_range  = ({1'b0, ptr_q} < QN);
    rd_idx    = in_range ? ptr_q : '0;
    rd_entry  = mem_q[rd_idx];
    lev_match = (lsel_q == '0) || (rd_entry[ENT_W-1 -: LEV_W] == lsel_q);
    hit       = busy && (dir_q ? in_range : (!used_q[rd_idx] && lev_match));
    exhausted = busy && !hit && (dir_q || (cnt_q + 1'b1 == QN));
  end

  // Next-state logic: a request opens a scan, a hit or exhaustion closes it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (REQ) state_d = S_SCAN;
      S_SCAN:  if (hit || exhausted) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (CLR_USED) state_d = S_IDLE;
  end

  // Datapath next values: memory writes, request capture, scan step, serve.
  always_comb begin
    mem_d    = mem_q;
    used_d   = used_q;
    last_d   = last_q;
    lfsr_d   = lfsr_step(lfsr_q);
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    lsel_d   = lsel_q;
    arr_d    = arr_q;
    ans_d    = ans_q;
    lev_d    = lev_q;
    qid_d    = qid_q;
    valid_d  = 1'b0;
    empty_d  = 1'b0;
    remain_d = remain_q;

    // The write lands on the request edge, so a scan started there sees it.
    if (WE && !busy && ({1'b0, WADDR} < QN)) mem_d[WADDR] = WDATA;

    if (!busy && REQ) begin
      dir_d  = (MODE == 2'd2);
      lsel_d = LEVEL_SEL;
      cnt_d  = '0;
      case (MODE)
        2'd1:    ptr_d = IDX_W'(lfsr_q % QN16);
        2'd2:    ptr_d = REQ_ID;
        default: ptr_d = inc_wrap(last_q);
      endcase
    end else if (hit) begin
      arr_d   = rd_entry[ARR_W-1:0];
      ans_d   = rd_entry[ARR_W +: ANS_W];
      lev_d   = rd_entry[ENT_W-1 -: LEV_W];
      qid_d   = ptr_q;
      valid_d = 1'b1;
      used_d[rd_idx] = 1'b1;
      if (!used_q[rd_idx]) remain_d = remain_q - 1'b1;
      if (!dir_q) last_d = ptr_q;
    end else if (exhausted) begin
      empty_d = 1'b1;
    end else if (busy) begin
      ptr_d = inc_wrap(ptr_q);
      cnt_d = cnt_q + 1'b1;
    end

    // Clearing the used mask wins over everything, including a same-cycle hit.
    if (CLR_USED) begin
      used_d   = '0;
      remain_d = QN;
      last_d   = LAST_ID;
      valid_d  = 1'b0;
      empty_d  = 1'b0;
      arr_d    = arr_q;
      ans_d    = ans_q;
      lev_d    = lev_q;
      qid_d    = qid_q;
    end
  end

  // Datapath registers; the question memory is deliberately kept across reset.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
    if (RST) begin
      used_q   <= '0;
      last_q   <= LAST_ID;
      lfsr_q   <= 16'hACE1;
      ptr_q    <= '0;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      lsel_q   <= '0;
      arr_q    <= '0;
      ans_q    <= '0;
      lev_q    <= '0;
      qid_q    <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b0;
      remain_q <= QN;
    end else begin
      used_q   <= used_d;
      last_q   <= last_d;
      lfsr_q   <= lfsr_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      lsel_q   <= lsel_d;
      arr_q    <= arr_d;
      ans_q    <= ans_d;
      lev_q    <= lev_d;
      qid_q    <= qid_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      remain_q <= remain_d;
    end
  end

  assign NUM_ARRAY = arr_q;
  assign ANSER     = ans_q;
  assign LEVEL     = lev_q;
  assign Q_ID      = qid_q;
  assign VALID     = valid_q;
  assign EMPTY     = empty_q;
  assign BUSY      = busy;
  assign REMAIN    = remain_q;

endmodule

// File: tb/tb_question_bank.sv
// Testbench for question_bank: scenario tasks compared against a behavioural
// model of the store (entry array, used flags, last id and a reference LFSR).
module tb_question_bank;

  localparam int NQ = 16;
  localparam int IW = 5;
  localparam int AW = 36;
  localparam int NW = 8;
  localparam int LW = 2;
  localparam int EW = LW + NW + AW;

  logic          clk = 1'b0;
  logic          rst, we, req, clr;
  logic [IW-1:0] waddr, req_id;
  logic [EW-1:0] wdata;
  logic [1:0]    mode;
  logic [LW-1:0] lsel;
  logic [AW-1:0] num_array;
  logic [NW-1:0] anser;
  logic [LW-1:0] level;
  logic [IW-1:0] q_id;
  logic          valid, empty, busy;
  logic [IW:0]   remain;

  question_bank #(.NUM_Q(NQ), .ARR_W(AW), .ANS_W(NW), .LEV_W(LW), .IDX_W(IW)) dut (
    .CLK(clk), .RST(rst), .WE(we), .WADDR(waddr), .WDATA(wdata),
    .REQ(req), .MODE(mode), .LEVEL_SEL(lsel), .REQ_ID(req_id), .CLR_USED(clr),
    .NUM_ARRAY(num_array), .ANSER(anser), .LEVEL(level), .Q_ID(q_id),
    .VALID(valid), .EMPTY(empty), .BUSY(busy), .REMAIN(remain)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model
  logic [EW-1:0] m_mem [NQ];
  bit            m_used [NQ];
  int            m_remain;
  int            m_last;
  logic [15:0]   ref_lfsr;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  always @(posedge clk) ref_lfsr <= rst ? 16'hACE1 : lfsr_next(ref_lfsr);

  // Observed results of the last request and model predictions
  bit g_v, g_e, g_bk;
  int g_lat;
  bit e_hit;
  int e_id, e_lat;

  task automatic model_clear();
    for (int i = 0; i < NQ; i++) m_used[i] = 1'b0;
    m_remain = NQ;
    m_last   = NQ - 1;
  endtask

  // Search from the mode's start point for the first eligible entry.
  task automatic predict(input logic [1:0] md, input logic [LW-1:0] ls, input int rid);
    int s, c;
    e_hit = 1'b0; e_id = -1; e_lat = NQ;
    if (md == 2'd2) begin
      e_lat = 1;
      if (rid < NQ) begin e_hit = 1'b1; e_id = rid; end
      return;
    end
    s = (md == 2'd1) ? int'(ref_lfsr % 16'(NQ)) : (m_last + 1) % NQ;
    for (int j = 0; j < NQ; j++) begin
      c = (s + j) % NQ;
      if (!m_used[c] && (ls == 0 || m_mem[c][EW-1 -: LW] == ls)) begin
        e_hit = 1'b1; e_id = c; e_lat = j + 1;
        break;
      end
    end
  endtask

  task automatic model_commit(input bit direct);
    if (e_hit) begin
      if (!m_used[e_id]) m_remain--;
      m_used[e_id] = 1'b1;
      if (!direct) m_last = e_id;
    end
  endtask

  // Issue one request (optionally with a same-edge write) and wait for VALID/EMPTY.
  task automatic do_req(input logic [1:0] md, input logic [LW-1:0] ls, input int rid,
                        input bit wen, input int wa, input logic [EW-1:0] wd);
    mode = md; lsel = ls; req_id = IW'(rid); req = 1'b1;
    we = wen; waddr = IW'(wa); wdata = wd;
    @(posedge clk); #1;
    req = 1'b0; we = 1'b0;
    g_bk = busy; g_lat = 0; g_v = 1'b0; g_e = 1'b0;
    while (g_lat < 40 && !g_v && !g_e) begin
      @(posedge clk); #1;
      g_lat++;
      g_v = valid; g_e = empty;
    end
  endtask

  task automatic pulse_clr();
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; req = 1'b0; clr = 1'b0;
    waddr = '0; wdata = '0; mode = '0; lsel = '0; req_id = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_clear();
    n_total++; if ({valid, empty, busy} !== 3'b000) $display("FAIL reset_flags got %b want 000", {valid, empty, busy}); else n_pass++;
    n_total++; if (remain !== 6'd16) $display("FAIL reset_remain got %0d want 16", remain); else n_pass++;
    n_total++; if ({num_array, anser, level, q_id} !== '0) $display("FAIL reset_data got %h want 0", {num_array, anser, level, q_id}); else n_pass++;
  endtask

  task automatic fill_table();
    for (int i = 0; i < NQ; i++) begin
      we = 1'b1; waddr = IW'(i);
      wdata = {LW'(i % 3), NW'(i), AW'(i * 7)};
      m_mem[i] = wdata;
      @(posedge clk); #1;
    end
    we = 1'b1; waddr = IW'(20); wdata = '1;
    @(posedge clk); #1;
    we = 1'b0;
  endtask

  task automatic test_sequential();
    int bad_id = 0, bad_lat = 0, bad_data = 0, bad_rem = 0;
    for (int i = 0; i < NQ; i++) begin
      predict(2'd0, '0, 0);
      do_req(2'd0, '0, 0, 1'b0, 0, '0);
      model_commit(1'b0);
      if (!g_v || q_id !== IW'(i)) bad_id++;
      if (g_lat != 1) bad_lat++;
      if (anser !== NW'(i) || num_array !== AW'(i * 7) || level !== LW'(i % 3)) bad_data++;
      if (remain !== 6'(NQ - 1 - i)) bad_rem++;
    end
    n_total++; if (bad_id != 0) $display("FAIL seq_ids wrong=%0d want 0", bad_id); else n_pass++;
    n_total++; if (bad_lat != 0) $display("FAIL seq_latency wrong=%0d want 0", bad_lat); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL seq_data wrong=%0d want 0", bad_data); else n_pass++;
    n_total++; if (bad_rem != 0) $display("FAIL seq_remain wrong=%0d want 0", bad_rem); else n_pass++;
    do_req(2'd0, '0, 0, 1'b0, 0, '0);
    n_total++; if (!g_e || g_v) $display("FAIL seq_exhaust_empty got v=%0b e=%0b want v=0 e=1", g_v, g_e); else n_pass++;
    n_total++; if (g_lat != 16) $display("FAIL seq_exhaust_latency got %0d want 16", g_lat); else n_pass++;
  endtask

  task automatic test_level_filter();
    int want [5] = '{2, 5, 8, 11, 14};
    pulse_clr();
    n_total++; if (remain !== 6'd16) $display("FAIL clr_remain got %0d want 16", remain); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      predict(2'd0, 2'd2, 0);
      do_req(2'd0, 2'd2, 0, 1'b0, 0, '0);
      model_commit(1'b0);
      n_total++;
      if (!g_v || q_id !== IW'(want[k]) || level !== 2'd2 || g_lat != e_lat)
        $display("FAIL level_serve%0d got v=%0b id=%0d lev=%0d lat=%0d want v=1 id=%0d lev=2 lat=%0d",
                 k, g_v, q_id, level, g_lat, want[k], e_lat);
      else n_pass++;
    end
    do_req(2'd0, 2'd2, 0, 1'b0, 0, '0);
    n_total++; if (!g_e || g_lat != 16) $display("FAIL level_empty got e=%0b lat=%0d want e=1 lat=16", g_e, g_lat); else n_pass++;
    n_total++; if (remain !== 6'd11) $display("FAIL level_remain got %0d want 11", remain); else n_pass++;
  endtask

  task automatic test_direct();
    int r1;
    predict(2'd2, '0, 7);
    do_req(2'd2, '0, 7, 1'b0, 0, '0);
    model_commit(1'b1);
    r1 = int'(remain);
    n_total++; if (!g_v || g_lat != 1 || anser !== 8'd7 || q_id !== 5'd7) $display("FAIL direct7_first got v=%0b lat=%0d ans=%0d id=%0d want 1/1/7/7", g_v, g_lat, anser, q_id); else n_pass++;
    n_total++; if (r1 != m_remain) $display("FAIL direct7_remain got %0d want %0d", r1, m_remain); else n_pass++;
    predict(2'd2, '0, 7);
    do_req(2'd2, 2'd1, 7, 1'b0, 0, '0);
    model_commit(1'b1);
    n_total++; if (!g_v || anser !== 8'd7) $display("FAIL direct7_second got v=%0b ans=%0d want v=1 ans=7", g_v, anser); else n_pass++;
    n_total++; if (int'(remain) != r1) $display("FAIL direct7_no_double_dec got %0d want %0d", remain, r1); else n_pass++;
    do_req(2'd2, '0, 20, 1'b0, 0, '0);
    n_total++; if (!g_e || g_v || g_lat != 1) $display("FAIL direct20_empty got v=%0b e=%0b lat=%0d want v=0 e=1 lat=1", g_v, g_e, g_lat); else n_pass++;
    n_total++; if (q_id !== 5'd7 || anser !== 8'd7) $display("FAIL direct20_hold got id=%0d ans=%0d want 7/7", q_id, anser); else n_pass++;
  endtask

  task automatic test_random();
    bit seen [NQ];
    int dups = 0, bad = 0, first_want = -1, first_got = -1;
    pulse_clr();
    for (int i = 0; i < NQ; i++) seen[i] = 1'b0;
    for (int i = 0; i < NQ; i++) begin
      if (i == 0) first_want = int'(ref_lfsr % 16'd16);
      predict(2'd1, '0, 0);
      do_req(2'd1, '0, 0, 1'b0, 0, '0);
      model_commit(1'b0);
      if (i == 0) first_got = int'(q_id);
      if (!g_v || int'(q_id) != e_id || g_lat != e_lat) bad++;
      if (g_v && int'(q_id) < NQ) begin
        if (seen[q_id]) dups++;
        seen[q_id] = 1'b1;
      end
    end
    n_total++; if (first_got != first_want) $display("FAIL rand_first_id got %0d want %0d", first_got, first_want); else n_pass++;
    n_total++; if (dups != 0) $display("FAIL rand_repeats got %0d want 0", dups); else n_pass++;
    n_total++; if (bad != 0) $display("FAIL rand_sequence wrong=%0d want 0", bad); else n_pass++;
    n_total++; if (remain !== 6'd0) $display("FAIL rand_remain got %0d want 0", remain); else n_pass++;
  endtask

  task automatic test_abort();
    int stray = 0;
    we = 1'b1; waddr = 5'd15; wdata = {2'd3, 8'd15, 36'd105};
    m_mem[15] = wdata;
    @(posedge clk); #1; we = 1'b0;
    pulse_clr();
    // CLR_USED mid-scan
    mode = 2'd0; lsel = 2'd3; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_start got %0b want 1", busy); else n_pass++;
    repeat (4) begin @(posedge clk); #1; if (valid || empty) stray++; end
    clr = 1'b1; @(posedge clk); #1; clr = 1'b0;
    model_clear();
    n_total++; if ({busy, valid, empty} !== 3'b000) $display("FAIL abort_clr_flags got %b want 000", {busy, valid, empty}); else n_pass++;
    n_total++; if (remain !== 6'd16) $display("FAIL abort_clr_remain got %0d want 16", remain); else n_pass++;
    repeat (20) begin @(posedge clk); #1; if (valid || empty) stray++; end
    n_total++; if (stray != 0) $display("FAIL abort_clr_stray got %0d want 0", stray); else n_pass++;
    predict(2'd0, '0, 0);
    do_req(2'd0, '0, 0, 1'b0, 0, '0);
    model_commit(1'b0);
    n_total++; if (!g_v || q_id !== 5'd0) $display("FAIL abort_clr_next got v=%0b id=%0d want v=1 id=0", g_v, q_id); else n_pass++;
    // RST mid-scan
    stray = 0;
    mode = 2'd0; lsel = 2'd3; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (valid || empty) stray++; end
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_clear();
    n_total++; if ({busy, valid, empty} !== 3'b000 || remain !== 6'd16 || q_id !== 5'd0) $display("FAIL abort_rst_state got bve=%b rem=%0d id=%0d want 000/16/0", {busy, valid, empty}, remain, q_id); else n_pass++;
    repeat (20) begin @(posedge clk); #1; if (valid || empty) stray++; end
    n_total++; if (stray != 0) $display("FAIL abort_rst_stray got %0d want 0", stray); else n_pass++;
    predict(2'd0, 2'd3, 0);
    do_req(2'd0, 2'd3, 0, 1'b0, 0, '0);
    model_commit(1'b0);
    n_total++; if (!g_v || q_id !== 5'd15 || anser !== 8'd15 || num_array !== 36'd105) $display("FAIL abort_rst_mem_kept got v=%0b id=%0d ans=%0d want v=1 id=15 ans=15", g_v, q_id, anser); else n_pass++;
  endtask

  task automatic test_write_with_req();
    int lat = 0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    model_clear();
    m_mem[0] = {2'd0, 8'hAA, 36'd0};
    predict(2'd0, '0, 0);
    do_req(2'd0, '0, 0, 1'b1, 0, {2'd0, 8'hAA, 36'd0});
    model_commit(1'b0);
    n_total++; if (!g_v || g_lat != 1 || q_id !== 5'd0 || anser !== 8'hAA) $display("FAIL we_req_same_edge got v=%0b lat=%0d id=%0d ans=%h want 1/1/0/aa", g_v, g_lat, q_id, anser); else n_pass++;
    // Write attempts while a scan is in progress must be ignored.
    mode = 2'd0; lsel = 2'd3; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    we = 1'b1; waddr = 5'd1; wdata = {2'd1, 8'h55, 36'd99};
    repeat (3) begin @(posedge clk); #1; lat++; end
    we = 1'b0;
    while (lat < 40 && !valid && !empty) begin @(posedge clk); #1; lat++; end
    n_total++; if (!valid || q_id !== 5'd15) $display("FAIL we_busy_scan got v=%0b id=%0d want v=1 id=15", valid, q_id); else n_pass++;
    m_used[15] = 1'b1; m_remain--; m_last = 15;
    do_req(2'd2, '0, 1, 1'b0, 0, '0);
    n_total++; if (!g_v || anser !== 8'd1 || num_array !== 36'd7) $display("FAIL we_busy_ignored got ans=%0d arr=%0d want ans=1 arr=7", anser, num_array); else n_pass++;
    m_used[1] = 1'b1; m_remain--;
  endtask

  task automatic test_random_mix();
    int bad_flag = 0, bad_id = 0, bad_data = 0, bad_rem = 0;
    logic [1:0]    md;
    logic [LW-1:0] ls;
    int            rid, wa;
    bit            wen;
    logic [EW-1:0] wd;
    pulse_clr();
    for (int it = 0; it < 60; it++) begin
      if (it % 20 == 19) pulse_clr();
      md  = 2'($urandom_range(0, 3));
      ls  = LW'($urandom_range(0, 3));
      rid = $urandom_range(0, 20);
      wen = ($urandom_range(0, 3) == 0);
      wa  = $urandom_range(0, 19);
      wd  = {LW'($urandom), NW'($urandom), AW'({$urandom, $urandom})};
      if (wen && wa < NQ) m_mem[wa] = wd;
      predict(md, ls, rid);
      do_req(md, ls, rid, wen, wa, wd);
      model_commit(md == 2'd2);
      if (g_v != e_hit || g_e != !e_hit || g_lat != e_lat) bad_flag++;
      else if (e_hit) begin
        if (int'(q_id) != e_id) bad_id++;
        else if ({level, anser, num_array} !== m_mem[e_id]) bad_data++;
      end
      if (int'(remain) != m_remain) bad_rem++;
    end
    n_total++; if (bad_flag != 0) $display("FAIL mix_flags_latency wrong=%0d want 0", bad_flag); else n_pass++;
    n_total++; if (bad_id != 0) $display("FAIL mix_ids wrong=%0d want 0", bad_id); else n_pass++;
    n_total++; if (bad_data != 0) $display("FAIL mix_data wrong=%0d want 0", bad_data); else n_pass++;
    n_total++; if (bad_rem != 0) $display("FAIL mix_remain wrong=%0d want 0", bad_rem); else n_pass++;
  endtask

  initial begin
    test_reset();
    fill_table();
    test_sequential();
    test_level_filter();
    test_direct();
    test_random();
    test_abort();
    test_write_with_req();
    test_random_mix();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
